// File: rtl/present_key_sched.sv
// present_key_sched: PRESENT 80/128-bit key schedule emitting round keys in forward or reverse order
module present_key_sched #(
  parameter int KEY_SIZE = 80,
  parameter int ROUNDS   = 31
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [KEY_SIZE-1:0] key_in,
  input  logic                dir,
  input  logic                load_valid,
  output logic                load_ready,
  output logic [63:0]         rk_out,
  output logic [4:0]          rk_idx,
  output logic                rk_valid,
  input  logic                rk_ready,
  output logic                done
);
  localparam logic [63:0] SB  = 64'h21748FE3DA09B65C;
  localparam logic [63:0] ISB = 64'hA970364BD21C8FE5;
  localparam int          CL  = (KEY_SIZE == 80) ? 15 : 62;
  localparam logic [4:0]  RL  = 5'(ROUNDS);
  typedef enum logic [1:0] {IDLE, PRECOMP, EMIT} state_t;
  state_t state, state_n;
  logic [KEY_SIZE-1:0] key, key_n;
  logic [4:0] idx, idx_n;
  logic rdir, rdir_n, done_n, last;
  if (!(KEY_SIZE == 80 || KEY_SIZE == 128) || ROUNDS < 1 || ROUNDS > 31) begin : g_bad
    $error("present_key_sched: KEY_SIZE must be 80 or 128 and ROUNDS in 1..31");
  end
  function automatic logic [KEY_SIZE-1:0] fwd(input logic [KEY_SIZE-1:0] k, input logic [4:0] c);
    logic [KEY_SIZE-1:0] r;
    r = {k[KEY_SIZE-62:0], k[KEY_SIZE-1:KEY_SIZE-61]};
    r[KEY_SIZE-1 -: 4] = SB[{r[KEY_SIZE-1 -: 4], 2'b00} +: 4];
    if (KEY_SIZE == 128) r[KEY_SIZE-5 -: 4] = SB[{r[KEY_SIZE-5 -: 4], 2'b00} +: 4];
    r[CL +: 5] = r[CL +: 5] ^ c;
    return r;
  endfunction
  function automatic logic [KEY_SIZE-1:0] inv(input logic [KEY_SIZE-1:0] k, input logic [4:0] c);
    logic [KEY_SIZE-1:0] r;
    r = k;
    r[CL +: 5] = r[CL +: 5] ^ c;
    r[KEY_SIZE-1 -: 4] = ISB[{r[KEY_SIZE-1 -: 4], 2'b00} +: 4];
    if (KEY_SIZE == 128) r[KEY_SIZE-5 -: 4] = ISB[{r[KEY_SIZE-5 -: 4], 2'b00} +: 4];
    return {r[60:0], r[KEY_SIZE-1:61]};
  endfunction
  assign load_ready = state == IDLE;
  assign rk_valid   = state == EMIT;
  assign rk_out     = key[KEY_SIZE-1 -: 64];
  assign rk_idx     = idx;
  assign last       = rdir ? (idx == 5'd0) : (idx == RL);
  always_comb begin
    state_n = state;
    key_n   = key;
    idx_n   = idx;
    rdir_n  = rdir;
    done_n  = 1'b0;
    if (state == IDLE && load_valid) begin
      key_n   = key_in;
      rdir_n  = dir;
      idx_n   = dir ? 5'd1 : 5'd0;
      state_n = dir ? PRECOMP : EMIT;
    end else if (state == PRECOMP) begin
      key_n   = fwd(key, idx);
      idx_n   = (idx == RL) ? idx : idx + 5'd1;
      state_n = (idx == RL) ? EMIT : PRECOMP;
    end else if (state == EMIT && rk_ready) begin
      state_n = last ? IDLE : EMIT;
      done_n  = last;
      key_n   = last ? key : (rdir ? inv(key, idx) : fwd(key, idx + 5'd1));
      idx_n   = last ? idx : (rdir ? idx - 5'd1 : idx + 5'd1);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      key   <= '0;
      idx   <= '0;
      rdir  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      key   <= key_n;
      idx   <= idx_n;
      rdir  <= rdir_n;
      done  <= done_n;
    end
  end
endmodule

// File: tb/tb_present_key_sched.sv
// tb_present_key_sched: scoreboard bench for three schedule instances (80/31, 128/31, 80/1)
module tb_present_key_sched;
  typedef struct packed {
    logic [4:0]  idx;
    logic [63:0] rk;
    logic        last;
  } exp_t;
  logic clk, rst_n, dr, rdy, stall;
  logic [127:0] kin;
  logic [2:0] lv;
  logic [63:0] rko [3];
  logic [4:0] rki [3];
  logic rkv [3];
  logic lr [3];
  logic dn [3];
  exp_t q [3][$];
  logic edone [3];
  logic waiting [3];
  int lat [3];
  int explat [3];
  int ks [3] = '{80, 128, 80};
  int rn [3] = '{31, 31, 1};
  int sb [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};
  int vec, miss;
  present_key_sched #(.KEY_SIZE(80), .ROUNDS(31)) u0 (
    .clk(clk), .rst_n(rst_n), .key_in(kin[79:0]), .dir(dr), .load_valid(lv[0]), .load_ready(lr[0]),
    .rk_out(rko[0]), .rk_idx(rki[0]), .rk_valid(rkv[0]), .rk_ready(rdy), .done(dn[0]));
  present_key_sched #(.KEY_SIZE(128), .ROUNDS(31)) u1 (
    .clk(clk), .rst_n(rst_n), .key_in(kin), .dir(dr), .load_valid(lv[1]), .load_ready(lr[1]),
    .rk_out(rko[1]), .rk_idx(rki[1]), .rk_valid(rkv[1]), .rk_ready(rdy), .done(dn[1]));
  present_key_sched #(.KEY_SIZE(80), .ROUNDS(1)) u2 (
    .clk(clk), .rst_n(rst_n), .key_in(kin[79:0]), .dir(dr), .load_valid(lv[2]), .load_ready(lr[2]),
    .rk_out(rko[2]), .rk_idx(rki[2]), .rk_valid(rkv[2]), .rk_ready(rdy), .done(dn[2]));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [127:0] upd(input logic [127:0] k, input int w, input logic [4:0] c);
    logic [127:0] m, r;
    int p;
    m = (w == 128) ? {128{1'b1}} : {48'h0, {80{1'b1}}};
    r = ((k << 61) | (k >> (w - 61))) & m;
    r[w-4 +: 4] = 4'(sb[r[w-4 +: 4]]);
    if (w == 128) r[w-8 +: 4] = 4'(sb[r[w-8 +: 4]]);
    p = (w == 80) ? 15 : 62;
    r[p +: 5] = r[p +: 5] ^ c;
    return r;
  endfunction
  task automatic push(input int i, input logic [127:0] k, input logic d);
    logic [127:0] kk;
    logic [63:0] rk [$];
    exp_t e;
    kk = (ks[i] == 128) ? k : {48'h0, k[79:0]};
    for (int j = 0; j <= rn[i]; j++) begin
      rk.push_back(kk[ks[i]-1 -: 64]);
      if (j < rn[i]) kk = upd(kk, ks[i], 5'(j + 1));
    end
    for (int j = 0; j <= rn[i]; j++) begin
      e.idx  = d ? 5'(rn[i] - j) : 5'(j);
      e.rk   = d ? rk[rn[i] - j] : rk[j];
      e.last = (j == rn[i]);
      if (k == 128'h0 && e.idx == 5'd1) e.rk = (ks[i] == 80) ? 64'hC000_0000_0000_0000 : 64'hCC00_0000_0000_0000;
      if (k == 128'h0 && e.idx == 5'd0) e.rk = 64'h0;
      q[i].push_back(e);
    end
    explat[i] = d ? rn[i] + 1 : 1;
  endtask
  task automatic do_load(input logic [127:0] k, input logic d);
    kin = k;
    dr  = d;
    for (int i = 0; i < 3; i++) push(i, k, d);
    lv = 3'b111;
    @(posedge clk);
    #1;
    lv = 3'b000;
    for (int i = 0; i < 3; i++) begin
      waiting[i] = 1'b1;
      lat[i] = 0;
    end
  endtask
  task automatic junk_pulses(input int n);
    for (int c = 0; c < n; c++) begin
      kin = {$urandom, $urandom, $urandom, $urandom};
      dr  = 1'($urandom);
      lv  = {!lr[2], !lr[1], !lr[0]};
      @(posedge clk);
      #1;
    end
    lv = 3'b000;
  endtask
  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < 400 && !ok; c++) begin
      ok = lr[0] && lr[1] && lr[2] && q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0;
      if (!ok) begin
        @(posedge clk);
        #1;
      end
    end
    vec++;
    if (!ok) begin
      miss++;
      $display("FAIL idle_timeout: got busy, expected idle within 400 cycles");
    end
    repeat (2) @(posedge clk);
    #1;
  endtask
  initial begin
    forever begin
      @(posedge clk);
      #1;
      rdy = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        q[i].delete();
        edone[i]   = 1'b0;
        waiting[i] = 1'b0;
      end else begin
        vec++;
        if (dn[i] !== edone[i]) begin
          miss++;
          $display("FAIL done[%0d]: got %b expected %b", i, dn[i], edone[i]);
        end
        edone[i] = 1'b0;
        if (waiting[i]) begin
          lat[i]++;
          if (rkv[i] === 1'b1 || lat[i] > 40) begin
            waiting[i] = 1'b0;
            vec++;
            if (lat[i] != explat[i]) begin
              miss++;
              $display("FAIL latency[%0d]: got %0d cycles expected %0d", i, lat[i], explat[i]);
            end
          end
        end
        if (rkv[i] === 1'b1) begin
          vec++;
          if (q[i].size() == 0) begin
            miss++;
            $display("FAIL spurious_rk[%0d]: got rk_valid=1 idx %0d expected no key", i, rki[i]);
          end else if (rko[i] !== q[i][0].rk || rki[i] !== q[i][0].idx) begin
            miss++;
            $display("FAIL rk[%0d]: got idx %0d rk %h expected idx %0d rk %h", i, rki[i], rko[i], q[i][0].idx, q[i][0].rk);
          end
          if (q[i].size() != 0 && rdy) begin
            edone[i] = q[i][0].last;
            void'(q[i].pop_front());
          end
        end
      end
    end
  end
  initial begin
    vec = 0;
    miss = 0;
    rst_n = 1'b0;
    rdy = 1'b1;
    stall = 1'b0;
    lv = 3'b000;
    kin = '0;
    dr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      edone[i] = 1'b0;
      waiting[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      vec++;
      if (lr[i] !== 1'b1 || rkv[i] !== 1'b0 || rki[i] !== 5'd0 || rko[i] !== 64'h0) begin
        miss++;
        $display("FAIL reset[%0d]: got ready %b valid %b idx %0d rk %h expected 1 0 0 0", i, lr[i], rkv[i], rki[i], rko[i]);
      end
    end
    @(posedge clk);
    #1;
    do_load(128'h0, 1'b0);
    wait_idle();
    do_load(128'h0, 1'b1);
    wait_idle();
    stall = 1'b1;
    for (int t = 0; t < 8; t++) begin
      do_load({$urandom, $urandom, $urandom, $urandom}, 1'($urandom));
      junk_pulses(6);
      wait_idle();
    end
    stall = 1'b0;
    do_load({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    for (int c = 0; c < 60 && !(rkv[0] && rki[0] == 5'd10); c++) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      vec++;
      if (rkv[i] !== 1'b0 || lr[i] !== 1'b1) begin
        miss++;
        $display("FAIL abort[%0d]: got valid %b ready %b expected 0 1", i, rkv[i], lr[i]);
      end
    end
    @(posedge clk);
    #1;
    stall = 1'b1;
    do_load({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    wait_idle();
    do_load({$urandom, $urandom, $urandom, $urandom}, 1'b1);
    junk_pulses(10);
    wait_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
